clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider generalising the fixed divide-by-3 and divide-by-5 blocks. The divisor is any N from 2 to 2^WIDTH-1, is loaded at run time and is applied glitch-free at a period boundary. Odd ratios can optionally produce a 50% duty cycle. It sits beside the fixed dividers in the clocking area and drives strobes and derived clock enables.

---
 rtl/clk_div_prog.sv | 133 +++++++++++++
 tb/tb_clk_div_prog.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
//
// Divides clk by any N in 2..2^WIDTH-1. A new divisor is requested with
// load and takes effect at the first period boundary after the load edge,
// so a period never changes part-way through. Divisors below 2 are refused
// and flagged on rej.
//
// Optional feature (macro CLK_DIV_DUTY50_EN): a negedge-retimed copy of the
// output stretches the high phase by half a clk period for odd divisors,
// giving 50% duty. Without the macro, odd N is high (N-1)/2 cycles.
//
// Ports:
//   clk      in   input clock
//   rst      in   asynchronous active-low reset
//   en       in   count enable; low parks the divider with q low
//   div      in   requested divisor, sampled when load=1
//   load     in   one-cycle request to capture div
//   q        out  divided output
//   tick     out  one-cycle pulse at the start of each period
//   div_cur  out  divisor currently in effect
//   rej      out  one-cycle pulse: a load with div<2 was refused
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             load,
  output logic             q,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             rej
);

  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] Two    = WIDTH'(2);
  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DefCnt = DefDiv - One;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             q_pos_q, q_pos_d;
  logic             tick_q, tick_d;
  logic             rej_q, rej_d;

  logic [WIDTH-1:0] cnt_max;
  logic             load_ok;
  logic             wrap;

  // div_cur never drops below 2, so cnt_max cannot underflow.
  assign cnt_max = div_cur_q - One;
  assign load_ok = load && (div >= Two);
  assign wrap    = en && (cnt_q == cnt_max);

  always_comb begin
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    q_pos_d   = q_pos_q;
    tick_d    = 1'b0;
    rej_d     = load && !load_ok;

    if (load_ok) begin
      pend_d   = div;
      pend_v_d = 1'b1;
    end

    if (!en) begin
      // Park one step before the wrap so the next enabled edge starts a period.
      cnt_d   = cnt_max;
      q_pos_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (pend_v_q) begin
        // The old pending value is applied now; a same-edge load stays queued.
        div_cur_d = pend_q;
        pend_v_d  = load_ok;
      end
      q_pos_d = cnt_d < (div_cur_d >> 1);
    end else begin
      cnt_d   = cnt_q + One;
      q_pos_d = cnt_d < (div_cur_d >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= DefCnt;
      div_cur_q <= DefDiv;
      pend_q    <= DefDiv;
      pend_v_q  <= 1'b0;
      q_pos_q   <= 1'b0;
      tick_q    <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      q_pos_q   <= q_pos_d;
      tick_q    <= tick_d;
      rej_q     <= rej_d;
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  logic q_neg_q;

  // Half-cycle delayed copy; ORed in only for odd divisors to extend the high phase.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_pos_q;
    end
  end

  assign q = q_pos_q | (q_neg_q & div_cur_q[0]);
`else
  assign q = q_pos_q;
`endif

  assign tick    = tick_q;
  assign div_cur = div_cur_q;
  assign rej     = rej_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (WIDTH=8, DEFAULT_DIV=3).
// A table of per-edge vectors covers N=3, a mid-period load of 4, rejected
// loads of 1 and 0, a load of 5, a load coinciding with a wrap while another
// value is pending, and en low/high. Hand-written sequences follow for an
// asynchronous reset mid-high-phase and restart after en toggling.
module tb_clk_div_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] div;
  logic       load;
  logic       q;
  logic       tick;
  logic [7:0] div_cur;
  logic       rej;

  int checks = 0;
  int errors = 0;
  logic prev_qpos = 1'b0;

  clk_div_prog #(
    .WIDTH      (8),
    .DEFAULT_DIV(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .div    (div),
    .load   (load),
    .q      (q),
    .tick   (tick),
    .div_cur(div_cur),
    .rej    (rej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] div;
    logic       qpos;
    logic       tick;
    logic [7:0] dc;
    logic       rej;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic l, input logic [7:0] d, input logic qp,
                     input logic t, input logic [7:0] dc, input logic r);
    vec_t v;
    v.en = e; v.load = l; v.div = d; v.qpos = qp; v.tick = t; v.dc = dc; v.rej = r;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected q sampled just after a posedge; with the duty-50 option the
  // negedge copy still holds the previous high-phase value for odd divisors.
  task automatic chk_q(input string name, input logic qpos_exp, input logic [7:0] dc_exp);
    logic exp_q;
`ifdef CLK_DIV_DUTY50_EN
    exp_q = qpos_exp | (prev_qpos & dc_exp[0]);
`else
    exp_q = qpos_exp;
`endif
    prev_qpos = qpos_exp;
    chk(name, {7'd0, q}, {7'd0, exp_q});
  endtask

  task automatic step(input logic e, input logic l, input logic [7:0] d);
    en = e; load = l; div = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic qp, input logic t, input logic [7:0] dc,
                         input logic r);
    chk_q({tag, " q"}, qp, dc);
    chk({tag, " tick"}, {7'd0, tick}, {7'd0, t});
    chk({tag, " div_cur"}, div_cur, dc);
    chk({tag, " rej"}, {7'd0, rej}, {7'd0, r});
  endtask

  initial begin
    // en load div | qpos tick div_cur rej
    // N=3 from reset: first enabled edge wraps
    add(1, 0, 0, 1, 1, 3, 0);
    add(1, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 1, 1, 3, 0);
    // load 4 mid-period: current 3-period completes
    add(1, 1, 4, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 1, 1, 4, 0);
    add(1, 0, 0, 1, 0, 4, 0);
    add(1, 0, 0, 0, 0, 4, 0);
    add(1, 0, 0, 0, 0, 4, 0);
    add(1, 0, 0, 1, 1, 4, 0);
    // rejected loads 1 and 0
    add(1, 1, 1, 1, 0, 4, 1);
    add(1, 1, 0, 0, 0, 4, 1);
    add(1, 0, 0, 0, 0, 4, 0);
    add(1, 0, 0, 1, 1, 4, 0);
    // load 5
    add(1, 1, 5, 1, 0, 4, 0);
    add(1, 0, 0, 0, 0, 4, 0);
    add(1, 0, 0, 0, 0, 4, 0);
    add(1, 0, 0, 1, 1, 5, 0);
    add(1, 0, 0, 1, 0, 5, 0);
    add(1, 0, 0, 0, 0, 5, 0);
    add(1, 0, 0, 0, 0, 5, 0);
    add(1, 0, 0, 0, 0, 5, 0);
    add(1, 0, 0, 1, 1, 5, 0);
    // pend 2, then load 6 on the wrap edge: 2 now, 6 one period later
    add(1, 1, 2, 1, 0, 5, 0);
    add(1, 0, 0, 0, 0, 5, 0);
    add(1, 0, 0, 0, 0, 5, 0);
    add(1, 0, 0, 0, 0, 5, 0);
    add(1, 1, 6, 1, 1, 2, 0);
    add(1, 0, 0, 0, 0, 2, 0);
    add(1, 0, 0, 1, 1, 6, 0);
    add(1, 0, 0, 1, 0, 6, 0);
    add(1, 0, 0, 1, 0, 6, 0);
    add(1, 0, 0, 0, 0, 6, 0);
    add(1, 0, 0, 0, 0, 6, 0);
    add(1, 0, 0, 0, 0, 6, 0);
    add(1, 0, 0, 1, 1, 6, 0);
    // en low with a load of 3; it applies at the restart wrap
    add(0, 1, 3, 0, 0, 6, 0);
    add(0, 0, 0, 0, 0, 6, 0);
    add(1, 0, 0, 1, 1, 3, 0);
    add(1, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 1, 1, 3, 0);
    // load 7, then a rejected load on the wrap edge
    add(1, 1, 7, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 3, 0);
    add(1, 1, 0, 1, 1, 7, 1);

    rst = 1'b0; en = 1'b0; load = 1'b0; div = 8'd0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 8'd3, 1'b0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].load, vecs[i].div);
      chk_all($sformatf("row%0d", i), vecs[i].qpos, vecs[i].tick, vecs[i].dc, vecs[i].rej);
    end

    // Asynchronous reset in the high phase, away from any clock edge
    en = 1'b1; load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    prev_qpos = 1'b0;
    chk_all("async_rst", 1'b0, 1'b0, 8'd3, 1'b0);
    #2;
    rst = 1'b1;

    step(0, 0, 0);
    chk_all("rel_en0", 1'b0, 1'b0, 8'd3, 1'b0);
    step(1, 0, 0);
    chk_all("rel_wrap", 1'b1, 1'b1, 8'd3, 1'b0);
    step(1, 0, 0);
    chk_all("rel_cnt1", 1'b0, 1'b0, 8'd3, 1'b0);
    step(0, 0, 0);
    chk_all("tog_en0", 1'b0, 1'b0, 8'd3, 1'b0);
    step(1, 0, 0);
    chk_all("tog_wrap", 1'b1, 1'b1, 8'd3, 1'b0);
    step(1, 0, 0);
    chk_all("tog_cnt1", 1'b0, 1'b0, 8'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
